cordic_cmd_issuer: RTL and testbench

Host-side command issuer for the CORDIC engine cluster. Accepts one function request at a time (mode plus one or two 32-bit operands), serialises it into 48-bit command words on the write side of the engine's input FIFO, then drains the matching 48-bit tagged result from the engine's output FIFO. Results are presented to the host with tag checking and an optional response timeout.

---
 rtl/cordic_cmd_issuer.sv | 180 ++++++++++++++++++
 tb/tb_cordic_cmd_issuer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_cmd_issuer.sv
// Host-side command issuer for the CORDIC engine cluster: one request in, 48-bit command words out,
// one tagged result word back. Define CORDIC_ISSUER_TIMEOUT_EN to enable the response timeout.

module cordic_cmd_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_mode,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic        cmd_full,
    output logic        cmd_wr_en,
    output logic [47:0] cmd_wr_data,
    input  logic        rsp_empty,
    output logic        rsp_rd_en,
    input  logic [47:0] rsp_rd_data,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [15:0] res_tag,
    output logic        res_err,
    output logic        res_timeout,
    output logic        busy
);

    localparam logic [7:0] ModeAtan = 8'd8;

    typedef enum logic [2:0] {
        StIdle,
        StWrX,
        StWrY,
        StWait,
        StRdHold,
        StRdSample
    } state_e;

    state_e      state_q;
    logic [7:0]  mode_q;
    logic [31:0] x_q;
    logic [31:0] y_q;
    logic [15:0] exp_tag_q;
    logic        mode_ok;

    // Each engine family stamps its results with a fixed tag.
    function automatic logic [15:0] expected_tag(input logic [7:0] mode);
        case (mode)
            8'd1, 8'd2, 8'd4:   return 16'h000a;
            8'd3, 8'd8:         return 16'h000b;
            8'd9, 8'd10, 8'd11: return 16'h000c;
            8'd7:               return 16'h000d;
            8'd5:               return 16'h000e;
            8'd6:               return 16'h000f;
            default:            return 16'h0000;
        endcase
    endfunction

    assign mode_ok = (req_mode != 8'd0) && (req_mode <= 8'd11);

`ifdef CORDIC_ISSUER_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q;
    logic        res_timeout_q;
    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= 8'd0;
            x_q         <= 32'd0;
            y_q         <= 32'd0;
            exp_tag_q   <= 16'd0;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            cmd_wr_en   <= 1'b0;
            cmd_wr_data <= 48'd0;
            rsp_rd_en   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= 32'd0;
            res_tag     <= 16'd0;
            res_err     <= 1'b0;
`ifdef CORDIC_ISSUER_TIMEOUT_EN
            tmo_cnt_q     <= 16'd0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            cmd_wr_en <= 1'b0;
            rsp_rd_en <= 1'b0;
            res_valid <= 1'b0;
`ifdef CORDIC_ISSUER_TIMEOUT_EN
            res_timeout_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        mode_q    <= req_mode;
                        x_q       <= req_x;
                        y_q       <= req_y;
                        exp_tag_q <= expected_tag(req_mode);
                        if (mode_ok) begin
                            state_q   <= StWrX;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            // Rejected without touching either FIFO.
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_data  <= 32'd0;
                            res_tag   <= 16'd0;
                        end
                    end
                end
                StWrX: begin
                    if (!cmd_full) begin
                        cmd_wr_en   <= 1'b1;
                        cmd_wr_data <= {8'h00, mode_q, x_q};
                        state_q     <= (mode_q == ModeAtan) ? StWrY : StWait;
`ifdef CORDIC_ISSUER_TIMEOUT_EN
                        tmo_cnt_q <= 16'd0;
`endif
                    end
                end
                StWrY: begin
                    if (!cmd_full) begin
                        cmd_wr_en   <= 1'b1;
                        cmd_wr_data <= {8'h00, ModeAtan, y_q};
                        state_q     <= StWait;
`ifdef CORDIC_ISSUER_TIMEOUT_EN
                        tmo_cnt_q <= 16'd0;
`endif
                    end
                end
                StWait: begin
                    if (!rsp_empty) begin
                        rsp_rd_en <= 1'b1;
                        state_q   <= StRdHold;
                    end
`ifdef CORDIC_ISSUER_TIMEOUT_EN
                    else if (tmo_cnt_q == TmoLast) begin
                        state_q       <= StIdle;
                        req_ready     <= 1'b1;
                        busy          <= 1'b0;
                        res_valid     <= 1'b1;
                        res_err       <= 1'b1;
                        res_timeout_q <= 1'b1;
                        res_data      <= 32'd0;
                        res_tag       <= 16'd0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end
                StRdHold: begin
                    // FIFO read data needs a second edge to settle.
                    state_q <= StRdSample;
                end
                StRdSample: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    res_valid <= 1'b1;
                    res_data  <= rsp_rd_data[31:0];
                    res_tag   <= rsp_rd_data[47:32];
                    res_err   <= (rsp_rd_data[47:32] != exp_tag_q);
                end
                default: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_cmd_issuer.sv
// Directed bench for cordic_cmd_issuer: transaction-level expectation queues checked every cycle,
// plus literal cycle-accurate checks on the key sequences.

module tb_cordic_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_mode;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        cmd_full;
    logic        cmd_wr_en;
    logic [47:0] cmd_wr_data;
    logic        rsp_empty;
    logic        rsp_rd_en;
    logic [47:0] rsp_rd_data;
    logic        res_valid;
    logic [31:0] res_data;
    logic [15:0] res_tag;
    logic        res_err;
    logic        res_timeout;
    logic        busy;

    always #5 clk = ~clk;

    cordic_cmd_issuer #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_x      (req_x),
        .req_y      (req_y),
        .cmd_full   (cmd_full),
        .cmd_wr_en  (cmd_wr_en),
        .cmd_wr_data(cmd_wr_data),
        .rsp_empty  (rsp_empty),
        .rsp_rd_en  (rsp_rd_en),
        .rsp_rd_data(rsp_rd_data),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_err    (res_err),
        .res_timeout(res_timeout),
        .busy       (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] tag;
        logic        err;
        logic        tmo;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;

    logic [47:0] exp_cmd_q [$];
    res_t        exp_res_q [$];

    // Output-FIFO model: stimulus writes at n_push, the pop process reads at n_pop.
    logic [47:0] rsp_mem [64];
    int          n_push = 0;
    int          n_pop  = 0;
    assign rsp_empty = (n_push == n_pop);

    always @(posedge clk) begin
        if (rsp_rd_en && (n_pop != n_push)) begin
            rsp_rd_data <= rsp_mem[n_pop];
            n_pop       <= n_pop + 1;
        end
    end

    logic [15:0] tag_tbl [12] = '{16'h0, 16'ha, 16'ha, 16'hb, 16'ha, 16'he,
                                  16'hf, 16'hd, 16'hb, 16'hc, 16'hc, 16'hc};

    function automatic logic [15:0] exp_tag(input logic [7:0] m);
        return (m >= 8'd1 && m <= 8'd11) ? tag_tbl[m] : 16'h0;
    endfunction

    function automatic res_t mk_res(input logic [31:0] d, input logic [15:0] t, input logic e,
                                    input logic o);
        res_t r;
        r.data = d;
        r.tag  = t;
        r.err  = e;
        r.tmo  = o;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the transaction model.
    logic full_at_edge;
    logic rst_at_edge;
    always @(posedge clk) begin
        full_at_edge <= cmd_full;
        rst_at_edge  <= reset;
    end

    always @(negedge clk) begin
        if (cmd_wr_en) begin
            n_wr++;
            check("wr_while_full", {63'd0, full_at_edge}, 64'd0);
            check("wr_expected", {63'd0, exp_cmd_q.size() > 0}, 64'd1);
            if (exp_cmd_q.size() > 0) check("cmd_word", {16'd0, cmd_wr_data}, {16'd0, exp_cmd_q.pop_front()});
        end
        if (res_valid) begin
            check("res_expected", {63'd0, exp_res_q.size() > 0}, 64'd1);
            if (exp_res_q.size() > 0)
                check("res_fields", {14'd0, res_data, res_tag, res_err, res_timeout},
                      {14'd0, exp_res_q.pop_front()});
        end
        if (rst_at_edge === 1'b0 && reset === 1'b0)
            check("ready_vs_busy", {63'd0, req_ready}, {63'd0, !busy});
    end

    task automatic issue(input logic [7:0] m, input logic [31:0] x, input logic [31:0] y);
        int t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("issue_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_mode  = m;
        req_x     = x;
        req_y     = y;
        if (m >= 8'd1 && m <= 8'd11) begin
            exp_cmd_q.push_back({8'h00, m, x});
            if (m == 8'd8) exp_cmd_q.push_back({8'h00, 8'h08, y});
        end else begin
            exp_res_q.push_back(mk_res(32'd0, 16'd0, 1'b1, 1'b0));
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [47:0] w, input logic [7:0] m);
        rsp_mem[n_push % 64] = w;
        exp_res_q.push_back(mk_res(w[31:0], w[47:32], w[47:32] != exp_tag(m), 1'b0));
        n_push = n_push + 1;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((exp_res_q.size() != 0 || exp_cmd_q.size() != 0 || busy) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, exp_res_q.size() + exp_cmd_q.size(), 64'd0);
    endtask

    task automatic wait_res(input string name);
        int t = 0;
        while (!res_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, {63'd0, res_valid}, 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ready"}, {63'd0, req_ready}, 64'd0);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_strobes"}, {61'd0, cmd_wr_en, rsp_rd_en, res_valid}, 64'd0);
        check({name, "_cmd_data"}, {16'd0, cmd_wr_data}, 64'd0);
        check({name, "_res"}, {14'd0, res_data, res_tag, res_err, res_timeout}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_mode  = 8'd0;
        req_x     = 32'd0;
        req_y     = 32'd0;
        cmd_full  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", {63'd0, req_ready}, 64'd1);

        // Sine, uncongested: write after edge 1, read at N, result at N+2.
        issue(8'd1, 32'h0000_4000, 32'd0);
        check("sin_busy", {62'd0, busy, req_ready}, 64'd2);
        check("sin_no_wr_yet", {63'd0, cmd_wr_en}, 64'd0);
        @(posedge clk); #1;
        check("sin_wr", {63'd0, cmd_wr_en}, 64'd1);
        check("sin_word", {16'd0, cmd_wr_data}, 64'h0001_0000_4000);
        @(posedge clk); #1;
        check("sin_wr_single", {63'd0, cmd_wr_en}, 64'd0);
        respond(48'h000a_1234_5678, 8'd1);
        @(posedge clk); #1;
        check("sin_rd", {63'd0, rsp_rd_en}, 64'd1);
        @(posedge clk); #1;
        check("sin_rd_single", {62'd0, rsp_rd_en, res_valid}, 64'd0);
        @(posedge clk); #1;
        check("sin_res_valid", {62'd0, res_valid, req_ready}, 64'd3);
        check("sin_res", {15'd0, res_data, res_tag, res_err}, {15'd0, 32'h1234_5678, 16'h000a, 1'b0});
        @(posedge clk); #1;
        check("sin_res_pulse", {63'd0, res_valid}, 64'd0);

        // Arctan: x then y back-to-back.
        issue(8'd8, 32'h100, 32'h200);
        @(posedge clk); #1;
        check("atan_x", {15'd0, cmd_wr_en, cmd_wr_data}, {15'd0, 1'b1, 48'h0008_0000_0100});
        @(posedge clk); #1;
        check("atan_y", {15'd0, cmd_wr_en, cmd_wr_data}, {15'd0, 1'b1, 48'h0008_0000_0200});
        @(posedge clk); #1;
        check("atan_done_wr", {62'd0, cmd_wr_en, busy}, 64'd1);
        respond(48'h000b_0000_0c00, 8'd8);
        wait_done("atan_done");

        // Backpressure on a single-word request.
        cmd_full = 1'b1;
        w0 = n_wr;
        issue(8'd2, 32'h55, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        check("bp_held", n_wr, w0);
        cmd_full = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("bp_one_strobe", n_wr, w0 + 1);
        respond(48'h000a_0000_beef, 8'd2);
        wait_done("bp_done");

        // Backpressure between arctan x and y.
        w0 = n_wr;
        issue(8'd8, 32'h11, 32'h22);
        @(posedge clk); #1;
        cmd_full = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("bp_atan_held", n_wr, w0 + 1);
        cmd_full = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("bp_atan_y", n_wr, w0 + 2);
        respond(48'h000b_0000_0033, 8'd8);
        wait_done("bp_atan_done");

        // Tag mismatch still passes data through.
        issue(8'd9, 32'h7, 32'd0);
        respond(48'h000a_0000_0001, 8'd9);
        wait_res("mm_seen");
        check("mm_res", {15'd0, res_data, res_tag, res_err}, {15'd0, 32'h1, 16'h000a, 1'b1});
        wait_done("mm_done");

        // Invalid modes: immediate error, nothing written.
        w0 = n_wr;
        issue(8'h0c, 32'h1, 32'h2);
        check("inv_res", {13'd0, res_valid, res_err, req_ready, res_data, res_tag},
              {13'd0, 1'b1, 1'b1, 1'b1, 32'd0, 16'd0});
        check("inv_state", {62'd0, busy, cmd_wr_en}, 64'd0);
        @(posedge clk); #1;
        check("inv_pulse", {62'd0, res_valid, cmd_wr_en}, 64'd0);
        issue(8'h00, 32'h3, 32'h4);
        check("inv0_res", {62'd0, res_valid, res_err}, 64'd3);
        @(posedge clk); #1;
        check("inv_no_wr", n_wr, w0);

        // Response already waiting in the FIFO.
        respond(48'h000e_0000_abcd, 8'd5);
        issue(8'd5, 32'h99, 32'd0);
        wait_done("preload_done");

`ifdef CORDIC_ISSUER_TIMEOUT_EN
        // WAIT entered at edge 1; timeout fires on the 16th WAIT edge.
        issue(8'd3, 32'h9, 32'd0);
        exp_res_q.push_back(mk_res(32'd0, 16'd0, 1'b1, 1'b1));
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            check("tmo_pulse", {63'd0, res_valid}, {63'd0, k == 17});
        end
        check("tmo_flags", {62'd0, res_err, res_timeout}, 64'd3);
        wait_done("tmo_done");
        // Response arriving on the timeout edge wins.
        issue(8'd3, 32'h9, 32'd0);
        repeat (16) begin @(posedge clk); #1; end
        respond(48'h000b_0000_0077, 8'd3);
        @(posedge clk); #1;
        check("tmo_read_wins", {63'd0, rsp_rd_en}, 64'd1);
        wait_done("tmo_rw_done");
`else
        issue(8'd3, 32'h9, 32'd0);
        w0 = exp_res_q.size();
        repeat (40) begin @(posedge clk); #1; end
        check("no_tmo_busy", {62'd0, busy, res_timeout}, 64'd2);
        respond(48'h000b_0000_0077, 8'd3);
        wait_done("no_tmo_done");
`endif

        // Reset while waiting for a response.
        issue(8'd4, 32'h1, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_wait", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_wait");
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_release", {62'd0, req_ready, busy}, 64'd2);

        issue(8'd1, 32'h5, 32'd0);
        respond(48'h000a_0000_0042, 8'd1);
        wait_done("post_rst_done");

        check("all_cmds_seen", exp_cmd_q.size(), 64'd0);
        check("all_res_seen", exp_res_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
